// File: rtl/panel_debounce.sv
// Front-panel input conditioner: per-bit 2-flop sync, tick-sampled stability debounce,
// registered rise/fall pulses and sticky event flags. `event` is reserved, so the flags are `events`.
module panel_debounce_lane #(
    parameter int   STABLE_TICKS = 4,
    parameter int   CW           = 3,
    parameter logic RST_BIT      = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic sample,
    input  logic clr,
    output logic out,
    output logic rise,
    output logic fall,
    output logic evt,
    output logic evt_nxt
);
    logic [CW-1:0] cnt;

    // Set has priority over clear so an edge landing with clr is never lost.
    assign evt_nxt = rise | fall | (evt & ~clr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            out  <= RST_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
            evt  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            evt  <= evt_nxt;
            if (tick) begin
                if (sample == out) begin
                    cnt <= '0;
                end else if (cnt == CW'(STABLE_TICKS - 1)) begin
                    out  <= sample;
                    cnt  <= '0;
                    rise <= sample;
                    fall <= ~sample;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

module panel_debounce #(
    parameter int               WIDTH        = 4,
    parameter int               CLK_HZ       = 50000000,
    parameter int               TICK_HZ      = 50000,
    parameter int               STABLE_TICKS = 4,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] events,
    output logic             any_event,
    output logic             tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int DW  = $clog2(DIV);
    localparam int CW  = $clog2(STABLE_TICKS) + 1;

    logic [DW-1:0]           div_cnt;
    logic [1:0][WIDTH-1:0]   sync_pipe;
    logic [WIDTH-1:0]        evt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         div_cnt <= '0;
        else if (div_cnt == DW'(DIV - 1))     div_cnt <= '0;
        else                                  div_cnt <= div_cnt + DW'(1);
    end

    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_pipe <= {RESET_VAL, RESET_VAL};
        end else begin
            sync_pipe[0] <= in;
            sync_pipe[1] <= sync_pipe[0];
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        panel_debounce_lane #(
            .STABLE_TICKS (STABLE_TICKS),
            .CW           (CW),
            .RST_BIT      (RESET_VAL[gi])
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .tick    (tick),
            .sample  (sync_pipe[1][gi]),
            .clr     (clr[gi]),
            .out     (out[gi]),
            .rise    (rise[gi]),
            .fall    (fall[gi]),
            .evt     (events[gi]),
            .evt_nxt (evt_nxt[gi])
        );
    end

    // Registered from next-state flags so it lines up with events.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) any_event <= 1'b0;
        else          any_event <= |evt_nxt;
    end
endmodule

// File: tb/tb_panel_debounce.sv
// Directed table-driven bench for panel_debounce at DIV=10, STABLE_TICKS=4.
module tb_panel_debounce;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] din, clr;
    logic [3:0] out, rise, fall, events;
    logic       any_event, tick;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rise1_n = 0;
    int rise2_n = 0;

    panel_debounce #(
        .WIDTH(4), .CLK_HZ(100), .TICK_HZ(10), .STABLE_TICKS(4), .RESET_VAL(4'b0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in(din), .clr(clr),
        .out(out), .rise(rise), .fall(fall), .events(events),
        .any_event(any_event), .tick(tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rise[1]) rise1_n++;
        if (rise[2]) rise2_n++;
    end

    typedef struct {
        int         cyc;
        logic [3:0] in_v;
        logic [3:0] clr_v;
        logic [3:0] e_out;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
        logic [3:0] e_evt;
        logic       e_any;
    } vec_t;

    vec_t tbl[22];

    task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] o, r, f, e, input logic a);
        check(name, {out, rise, fall, events, any_event}, {o, r, f, e, a});
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        clr = 4'b0000;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            while (cyc < tbl[i].cyc) step();
            check_outs($sformatf("vec%0d@c%0d", i, cyc), tbl[i].e_out, tbl[i].e_rise,
                       tbl[i].e_fall, tbl[i].e_evt, tbl[i].e_any);
            din = tbl[i].in_v;
            clr = tbl[i].clr_v;
        end
    endtask

    initial begin
        //          cyc  in       clr      out      rise     fall     evt      any
        tbl[0]  = '{50,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[1]  = '{89,  4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[2]  = '{90,  4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0};
        tbl[3]  = '{91,  4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[4]  = '{100, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[5]  = '{115, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[6]  = '{130, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[7]  = '{169, 4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[8]  = '{170, 4'b0011, 4'b0000, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b1};
        tbl[9]  = '{171, 4'b0011, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1};
        tbl[10] = '{180, 4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b1};
        tbl[11] = '{181, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[12] = '{219, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[13] = '{220, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b0};
        tbl[14] = '{221, 4'b0010, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0001, 1'b1};
        tbl[15] = '{222, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[16] = '{260, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0};
        tbl[17] = '{261, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1};
        tbl[18] = '{262, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[19] = '{299, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
        tbl[20] = '{300, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1'b0};
        tbl[21] = '{301, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b1010, 1'b1};

        reset_n = 1'b0;
        din     = 4'b0000;
        clr     = 4'b0000;
        #12;
        check("reset_state", {out, rise, fall, events, any_event, tick, 3'b000},
                             {17'h0, 4'b0000});

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;

        // Steady state: first tick lands in cycle 9, then every 10 clocks.
        for (int c = 1; c <= 49; c++) begin
            step();
            check($sformatf("tick@c%0d", cyc), {16'h0, tick}, {16'h0, ((cyc % 10) == 9)});
            check_outs($sformatf("idle@c%0d", cyc), 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end

        run(0, 9);
        check("bounce_rise1_once", 17'(rise1_n), 17'd1);
        run(10, 21);

        // Reset in the middle of an in[2] debounce, with the input still held high.
        while (cyc < 310) step();
        din = 4'b1110;
        while (cyc < 335) step();
        reset_n = 1'b0;
        #1;
        check("midreset_clear", {out, rise, fall, events, any_event, tick, 3'b000},
                                {17'h0, 4'b0000});
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        while (cyc < 8) step();
        check("post_rst_tick8", {16'h0, tick}, 17'h0);
        step();
        check("post_rst_tick9", {16'h0, tick}, 17'h1);
        while (cyc < 39) step();
        check_outs("post_rst_c39", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step();
        check_outs("post_rst_c40", 4'b1110, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        step();
        check_outs("post_rst_c41", 4'b1110, 4'b0000, 4'b0000, 4'b1110, 1'b1);
        step();
        check("rise2_once", 17'(rise2_n), 17'd1);
        check("rise1_total", 17'(rise1_n), 17'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/panel_debounce.md
Name: panel_debounce

Overview:
- Parametrised front-panel input conditioner for the DE0 board: switches, keys and panel inputs.
- Successor to the fixed 4-bit, 50 kHz-sampled switch register.
- Per bit it provides two-flop synchronisation, a stability-count debounce, and one-clock rise/fall pulses.
- Per bit it also provides sticky event flags with software clear, for consumption by panel logic and Avalon-facing controllers.

Parameters:
- WIDTH, 4, number of independent input bits.
- CLK_HZ, 50000000, clk frequency in Hz.
- TICK_HZ, 50000, sample tick rate. DIV = CLK_HZ/TICK_HZ, which must be >= 2.
- STABLE_TICKS, 4, consecutive ticks an input must differ from out before out follows it. Must be >= 1.
- RESET_VAL, {WIDTH{1'b0}}, reset value of the synchroniser flops and of out.

Ports:
- clk  in  1  system clock (FPGA_CLK1_50 domain).
- reset_n  in  1  asynchronous, active-low reset.
- in  in  WIDTH  raw asynchronous inputs.
- clr  in  WIDTH  per-bit clear for the sticky flags. Level-sensitive, one clk per clear.
- out  out  WIDTH  debounced level.
- rise  out  WIDTH  one-clk pulse when the out bit goes 0->1.
- fall  out  WIDTH  one-clk pulse when the out bit goes 1->0.
- event  out  WIDTH  sticky flag, set by rise or fall of that bit.
- any_event  out  1  OR-reduction of event (interrupt request).
- tick  out  1  sample strobe, exported for observation.

Behaviour:
- Reset (async assert, sync release):
  - Divider counter = 0, tick = 0.
  - sync1/sync2 = RESET_VAL, out = RESET_VAL.
  - All stability counters = 0.
  - rise/fall/event/any_event = 0.
- Divider:
  - Counter runs 0..DIV-1 and wraps.
  - tick = 1 for exactly one clk when counter == DIV-1.
  - The first tick after reset release is in cycle DIV-1.
- Synchroniser: in -> sync1 -> sync2 on every clk, independent of tick.
- Per bit, stability counter cnt (width clog2(STABLE_TICKS)+1) updates only in tick cycles:
  - sync2 == out: cnt <= 0.
  - sync2 != out and cnt < STABLE_TICKS-1: cnt <= cnt+1.
  - sync2 != out and cnt == STABLE_TICKS-1: out <= sync2, cnt <= 0, and the corresponding rise or fall pulse asserts for exactly that next clk.
- Glitch rejection: any tick where sync2 == out resets cnt, so a bounce restarts the count.
- STABLE_TICKS = 1: out follows sync2 at the first tick where they differ.
- Latency from an in edge (then stable) to the out change: between 2+(STABLE_TICKS-1)*DIV+1 and 2+STABLE_TICKS*DIV clk.
- rise/fall are registered and aligned with the out transition (the cycle after the tick). rise and fall are never both high for the same bit.
- Sticky flags:
  - event[i] sets on rise[i] | fall[i].
  - event[i] clears when clr[i] = 1.
  - Simultaneous set and clear: set wins, so the event is not lost.
  - any_event is registered from the next-state event vector, so it is aligned with event.
- Bits are fully independent; simultaneous transitions on several bits are all reported in the same cycle.
- Reset mid-debounce discards partial counts and pending transitions. If in != RESET_VAL after release, out transitions through the normal debounce path and raises edges and events.
- Divider wrap is seamless; there is no tick drop or double tick across the wrap.

Test Plan:
- Reset + steady state: WIDTH=4, CLK_HZ=100, TICK_HZ=10 (DIV=10), STABLE_TICKS=4, in=4'b0000. Release reset_n → out=0; rise/fall/event=0 for 200 clk; tick high at cycles 9, 19, 29….
- Clean edge: at cycle 50, in[0] 0->1 and held → out[0]=1 between 2+31=33 and 42 clk later; rise[0] one-clk pulse coincident; event[0]=1; any_event=1; fall=0.
- Bounce rejection: in[1] toggled 1,0,1 with 15-clk spacing, then held 1 → out[1] stays 0 until 4 consecutive ticks see 1 after the last toggle; exactly one rise[1] pulse.
- Clear vs set: drive clr[0]=1 in the same clk that fall[0] pulses → event[0] stays 1. clr[0]=1 on the next clk → event[0]=0; any_event=0 if no other flags.
- Multi-bit: in 4'b0000 -> 4'b1010 simultaneously → rise=4'b1010 in a single cycle; out=4'b1010; event=4'b1010.
- Reset mid-count: in[2]=1 held for 2 ticks, assert reset_n=0 for 3 clk, release with in[2]=1 still held → out[2]=0 immediately after reset; out[2]=1 only after a full 4 ticks post-release; rise[2] pulses once.
